// File: rtl/serial_adder.sv
// Bit-serial adder: one bit per clock, LSB first, with valid/ready handshakes
// on the operand side and the result side.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   in_valid   operand set a/b/cin is valid
//   in_ready   block can accept operands this cycle
//   a, b       WIDTH-bit operands
//   cin        carry-in
//   out_valid  sum/cout valid
//   out_ready  consumer accepts result this cycle
//   sum        (a+b+cin) mod 2^WIDTH
//   cout       bit WIDTH of a+b+cin
//   busy       high while adding or holding a result
`timescale 1ns/1ps

module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        ADD,
        DONE
    } state_t;

    state_t          state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] sum_sh;
    logic [CW-1:0]    count;
    logic             carry;

    // Full-adder bit built from two half-adder stages.
    logic p;
    logic g;
    logic s;
    logic c_next;

    assign p      = a_sh[0] ^ b_sh[0];
    assign g      = a_sh[0] & b_sh[0];
    assign s      = p ^ carry;
    assign c_next = g | (carry & p);

    // New sum bit enters at the MSB so that after WIDTH shifts the
    // first (LSB) bit has reached position 0.
    generate
        if (WIDTH == 1) begin : g_w1
            assign sum_sh = s;
        end else begin : g_wn
            assign sum_sh = {s, sum[WIDTH-1:1]};
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            a_sh      <= '0;
            b_sh      <= '0;
            carry     <= 1'b0;
            count     <= '0;
            sum       <= '0;
            cout      <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    in_ready <= 1'b1;
                    // in_ready gates the accept so nothing is taken on the
                    // first edge after reset release.
                    if (in_valid && in_ready) begin
                        a_sh     <= a;
                        b_sh     <= b;
                        carry    <= cin;
                        count    <= '0;
                        sum      <= '0;
                        cout     <= 1'b0;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        state    <= ADD;
                    end
                end
                ADD: begin
                    a_sh  <= a_sh >> 1;
                    b_sh  <= b_sh >> 1;
                    carry <= c_next;
                    sum   <= sum_sh;
                    count <= count + 1'b1;
                    if (count == LAST) begin
                        cout      <= c_next;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
